// File: rtl/hazard_fwd_unit.sv
// -----------------------------------------------------------------------------
// hazard_fwd_unit
//
// Hazard detection and forwarding controller for the pipelined datapath.
// A scoreboard tracks in-flight register writers, one entry per pipeline slot
// after ID (slot 1 = EX, slot DEPTH = WB). From that scoreboard the unit
// produces:
//   * registered EX-stage forwarding selects for the ALU operand muxes,
//   * load-use stalls (PC / IF_ID hold plus an ID_EX bubble),
//   * redirect flushes for taken branches and jumps (IF_ID NOP, ID_EX bubble,
//     and a squash mask for the younger in-flight slots).
//
// Optional feature: define HAZARD_PERF_CNT_EN to build the saturating stall
// and flush performance counters. When it is undefined the counter ports
// remain and read 0.
//
// Parameters
//   AW             register address width
//   DEPTH          scoreboard slots after ID (2..8)
//   LOAD_STAGE     slot at whose end load data becomes forwardable (1..DEPTH-1)
//   REDIRECT_STAGE slot in which a taken branch/jump resolves (1..DEPTH-1)
//   CNT_W          performance counter width
//   FW             forwarding-select width, $clog2(DEPTH)
//
// Ports
//   clk            clock, all state updates on the rising edge
//   rst            asynchronous active-low reset
//   id_valid       ID holds a real instruction
//   id_rs, id_rt   ID source registers
//   id_rs_used,
//   id_rt_used     source is actually read
//   id_dst         ID destination register (after RegDst)
//   id_reg_write   ID instruction writes the register file
//   id_is_load     ID instruction is a load
//   redirect       instruction in slot REDIRECT_STAGE is a taken branch/jump
//   stall_out      hold PC and IF_ID this cycle
//   flush_if_id    IF_ID loads a NOP
//   bubble_id_ex   ID_EX loads a bubble
//   kill_mask      bit k-1 set: slot k must be squashed
//   ex_fwd_a_sel,
//   ex_fwd_b_sel   operand selects for the instruction now in EX
//                  (0 = register file, j = producer j stages ahead of EX)
//   slot_valid     scoreboard valid bits, bit k-1 = slot k
//   stall_cnt,
//   flush_cnt      performance counters
// -----------------------------------------------------------------------------
module hazard_fwd_unit #(
   parameter  int AW             = 5,
   parameter  int DEPTH          = 3,
   parameter  int LOAD_STAGE     = 2,
   parameter  int REDIRECT_STAGE = 2,
   parameter  int CNT_W          = 16,
   localparam int FW             = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [AW-1:0]    id_rs,
   input  logic [AW-1:0]    id_rt,
   input  logic             id_rs_used,
   input  logic             id_rt_used,
   input  logic [AW-1:0]    id_dst,
   input  logic             id_reg_write,
   input  logic             id_is_load,
   input  logic             redirect,
   output logic             stall_out,
   output logic             flush_if_id,
   output logic             bubble_id_ex,
   output logic [DEPTH-1:0] kill_mask,
   output logic [FW-1:0]    ex_fwd_a_sel,
   output logic [FW-1:0]    ex_fwd_b_sel,
   output logic [DEPTH-1:0] slot_valid,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef struct packed {
      logic          valid;
      logic          reg_write;
      logic          is_load;
      logic [AW-1:0] dst;
   } slot_t;

   // Loads in slots below this index cannot forward yet.
   localparam logic [FW-1:0] LOAD_K = FW'(LOAD_STAGE);

   // Array index i holds slot i+1.
   slot_t slots      [DEPTH];
   slot_t slots_next [DEPTH];

   logic [FW-1:0] rs_k, rt_k;        // youngest matching slot, 0 = none
   logic          rs_load, rt_load;  // that youngest match is a load
   logic          issue;

   // A slot can supply a source operand only if it really writes a nonzero
   // register that the ID instruction really reads.
   function automatic logic slot_hit(input slot_t s, input logic [AW-1:0] r,
                                     input logic used);
      return used && s.valid && s.reg_write && (s.dst == r) && (r != '0);
   endfunction

   // Youngest-match search. Slot DEPTH is excluded: the register file is
   // write-through, so the WB writer is already visible to ID. Scanning from
   // old to young lets the lowest matching slot overwrite older ones.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves
      // it unassigned, which would otherwise infer a latch.
      rs_k    = '0;
      rt_k    = '0;
      rs_load = 1'b0;
      rt_load = 1'b0;
      for (int k = DEPTH - 1; k >= 1; k--) begin
         if (slot_hit(slots[k-1], id_rs, id_rs_used)) begin
            rs_k    = FW'(k);
            rs_load = slots[k-1].is_load;
         end
         if (slot_hit(slots[k-1], id_rt, id_rt_used)) begin
            rt_k    = FW'(k);
            rt_load = slots[k-1].is_load;
         end
      end
   end

   // Redirect outranks stall, which outranks issue.
   assign stall_out    = !redirect && id_valid &&
                         ((rs_load && (rs_k < LOAD_K)) ||
                          (rt_load && (rt_k < LOAD_K)));
   assign flush_if_id  = redirect;
   assign bubble_id_ex = redirect || stall_out;
   assign issue        = id_valid && !stall_out && !redirect;

   // Slots younger than the redirecting one (1..REDIRECT_STAGE-1) are squashed.
   always_comb begin
      kill_mask = '0;
      for (int i = 0; i < DEPTH; i++) begin
         kill_mask[i] = redirect && (i < REDIRECT_STAGE - 1);
      end
   end

   // Next scoreboard contents: ID enters slot 1 only when it really issues;
   // a stall or redirect inserts an invalid entry instead. Squashed slots move
   // forward as invalid so the bubble travels with the pipeline.
   always_comb begin
      slots_next[0] = '0;
      if (issue) begin
         slots_next[0] = '{valid: 1'b1, reg_write: id_reg_write,
                           is_load: id_is_load, dst: id_dst};
      end
      for (int k = 1; k < DEPTH; k++) begin
         slots_next[k] = (redirect && (k < REDIRECT_STAGE)) ? '0 : slots[k-1];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         // NOTE: the scoreboard is reset, unlike a plain data array, because
         // stale valid bits would raise phantom hazards after reset.
         for (int k = 0; k < DEPTH; k++) begin
            slots[k] <= '0;
         end
         ex_fwd_a_sel <= '0;
         ex_fwd_b_sel <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // slot samples its predecessor's pre-edge value.
         for (int k = 0; k < DEPTH; k++) begin
            slots[k] <= slots_next[k];
         end
         // A bubble entering EX must never forward.
         ex_fwd_a_sel <= issue ? rs_k : '0;
         ex_fwd_b_sel <= issue ? rt_k : '0;
      end
   end

   always_comb begin
      slot_valid = '0;
      for (int k = 0; k < DEPTH; k++) begin
         slot_valid[k] = slots[k].valid;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   // Saturating counters: they stick at all-ones instead of wrapping.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall_out && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
         end
         if (redirect && (flush_cnt != '1)) begin
            flush_cnt <= flush_cnt + CNT_W'(1);
         end
      end
   end
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_fwd_unit
//
// Directed bench for hazard_fwd_unit. Two instances share clk and rst:
//   u_dut   default parameters (DEPTH=3, LOAD_STAGE=2, REDIRECT_STAGE=2)
//   u_small DEPTH=8, LOAD_STAGE=7, REDIRECT_STAGE=5, CNT_W=4, so that long
//           stalls, wide selects and counter saturation are reachable quickly.
// Inputs change just after the falling edge; outputs are sampled 1 time unit
// later (combinational) or at the falling edge after a rising edge (state).
// -----------------------------------------------------------------------------
module tb_hazard_fwd_unit;

`ifdef HAZARD_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic       clk;
   logic       rst;

   // default instance
   logic       id_valid, id_rs_used, id_rt_used, id_reg_write, id_is_load, redirect;
   logic [4:0] id_rs, id_rt, id_dst;
   logic       stall_out, flush_if_id, bubble_id_ex;
   logic [2:0] kill_mask, slot_valid;
   logic [1:0] ex_fwd_a_sel, ex_fwd_b_sel;
   logic [15:0] stall_cnt, flush_cnt;

   // small / deep instance
   logic       s_id_valid, s_id_rs_used, s_id_rt_used, s_id_reg_write, s_id_is_load, s_redirect;
   logic [4:0] s_id_rs, s_id_rt, s_id_dst;
   logic       s_stall_out, s_flush_if_id, s_bubble_id_ex;
   logic [7:0] s_kill_mask, s_slot_valid;
   logic [2:0] s_fwd_a_sel, s_fwd_b_sel;
   logic [3:0] s_stall_cnt, s_flush_cnt;

   int checks = 0;
   int errors = 0;
   int exp_stall = 0, exp_flush = 0;
   int s_exp_stall = 0, s_exp_flush = 0;

   hazard_fwd_unit u_dut (
      .clk(clk), .rst(rst),
      .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_dst(id_dst),
      .id_reg_write(id_reg_write), .id_is_load(id_is_load), .redirect(redirect),
      .stall_out(stall_out), .flush_if_id(flush_if_id), .bubble_id_ex(bubble_id_ex),
      .kill_mask(kill_mask), .ex_fwd_a_sel(ex_fwd_a_sel), .ex_fwd_b_sel(ex_fwd_b_sel),
      .slot_valid(slot_valid), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   hazard_fwd_unit #(.AW(5), .DEPTH(8), .LOAD_STAGE(7), .REDIRECT_STAGE(5), .CNT_W(4)) u_small (
      .clk(clk), .rst(rst),
      .id_valid(s_id_valid), .id_rs(s_id_rs), .id_rt(s_id_rt),
      .id_rs_used(s_id_rs_used), .id_rt_used(s_id_rt_used), .id_dst(s_id_dst),
      .id_reg_write(s_id_reg_write), .id_is_load(s_id_is_load), .redirect(s_redirect),
      .stall_out(s_stall_out), .flush_if_id(s_flush_if_id), .bubble_id_ex(s_bubble_id_ex),
      .kill_mask(s_kill_mask), .ex_fwd_a_sel(s_fwd_a_sel), .ex_fwd_b_sel(s_fwd_b_sel),
      .slot_valid(s_slot_valid), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------------------------------------------------------- helpers
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic rsu, input logic rtu, input logic [4:0] dst,
                         input logic rw, input logic ld);
      id_valid = v; id_rs = rs; id_rt = rt; id_rs_used = rsu; id_rt_used = rtu;
      id_dst = dst; id_reg_write = rw; id_is_load = ld;
   endtask

   task automatic s_set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                           input logic rsu, input logic rtu, input logic [4:0] dst,
                           input logic rw, input logic ld);
      s_id_valid = v; s_id_rs = rs; s_id_rt = rt; s_id_rs_used = rsu; s_id_rt_used = rtu;
      s_id_dst = dst; s_id_reg_write = rw; s_id_is_load = ld;
   endtask

   task automatic drain(input int n);
      set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
      s_set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
      redirect = 1'b0;
      s_redirect = 1'b0;
      repeat (n) step();
   endtask

   // ------------------------------------------------------------------ tests
   task automatic test_reset();
      rst = 1'b0;
      drain(0);
      @(negedge clk);
      checks++; if (slot_valid !== 3'b000) begin errors++; $display("FAIL reset_slot_valid: got %b expected 000", slot_valid); end
      checks++; if (ex_fwd_a_sel !== 2'd0 || ex_fwd_b_sel !== 2'd0) begin errors++; $display("FAIL reset_sel: got a=%0d b=%0d expected 0/0", ex_fwd_a_sel, ex_fwd_b_sel); end
      checks++; if ({stall_out, flush_if_id, bubble_id_ex, kill_mask} !== 6'b0) begin errors++; $display("FAIL reset_ctrl: got %b expected 000000", {stall_out, flush_if_id, bubble_id_ex, kill_mask}); end
      checks++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0h/%0h expected 0/0", stall_cnt, flush_cnt); end
      checks++; if (s_slot_valid !== 8'h00 || s_fwd_a_sel !== 3'd0) begin errors++; $display("FAIL reset_small: got valid=%0h sel=%0d expected 0/0", s_slot_valid, s_fwd_a_sel); end
      rst = 1'b1;
   endtask

   task automatic test_alu_fwd();
      drain(4);
      set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);   // add $3,$1,$2
      #1;
      checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL alu_first_stall: got %b expected 0", stall_out); end
      step();
      set_id(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);   // add $4,$3,$3
      #1;
      checks++; if (stall_out !== 1'b0 || bubble_id_ex !== 1'b0) begin errors++; $display("FAIL alu_b2b_stall: got stall=%b bubble=%b expected 0/0", stall_out, bubble_id_ex); end
      step();
      checks++; if (ex_fwd_a_sel !== 2'd1 || ex_fwd_b_sel !== 2'd1) begin errors++; $display("FAIL alu_fwd_sel: got a=%0d b=%0d expected 1/1", ex_fwd_a_sel, ex_fwd_b_sel); end
      checks++; if (slot_valid !== 3'b011) begin errors++; $display("FAIL alu_slot_valid: got %b expected 011", slot_valid); end
   endtask

   task automatic test_load_use();
      drain(4);
      set_id(1'b1, 5'd1, 5'd4, 1'b1, 1'b0, 5'd4, 1'b1, 1'b1);   // lw $4,0($1)
      #1;
      checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL lu_load_stall: got %b expected 0", stall_out); end
      step();
      set_id(1'b1, 5'd4, 5'd0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);   // add $5,$4,$0
      #1;
      checks++; if (stall_out !== 1'b1 || bubble_id_ex !== 1'b1 || flush_if_id !== 1'b0) begin errors++; $display("FAIL lu_stall: got stall=%b bubble=%b flush=%b expected 1/1/0", stall_out, bubble_id_ex, flush_if_id); end
      exp_stall++;
      step();
      checks++; if (ex_fwd_a_sel !== 2'd0 || ex_fwd_b_sel !== 2'd0) begin errors++; $display("FAIL lu_bubble_sel: got a=%0d b=%0d expected 0/0", ex_fwd_a_sel, ex_fwd_b_sel); end
      #1;
      checks++; if (stall_out !== 1'b0 || bubble_id_ex !== 1'b0) begin errors++; $display("FAIL lu_stall_len: got stall=%b bubble=%b expected 0/0", stall_out, bubble_id_ex); end
      step();
      checks++; if (ex_fwd_a_sel !== 2'd2 || ex_fwd_b_sel !== 2'd0) begin errors++; $display("FAIL lu_fwd_sel: got a=%0d b=%0d expected 2/0", ex_fwd_a_sel, ex_fwd_b_sel); end
   endtask

   task automatic test_youngest();
      drain(4);
      set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd2, 1'b1, 1'b0);   // older writer of $2
      step();
      set_id(1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b0);   // younger writer of $2
      step();
      set_id(1'b1, 5'd2, 5'd2, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0);  // reads $2 twice
      #1;
      checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL young_stall: got %b expected 0", stall_out); end
      step();
      checks++; if (ex_fwd_a_sel !== 2'd1 || ex_fwd_b_sel !== 2'd1) begin errors++; $display("FAIL young_sel: got a=%0d b=%0d expected 1/1", ex_fwd_a_sel, ex_fwd_b_sel); end

      drain(4);
      set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1);   // load to $0
      step();
      set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);   // reads $0
      #1;
      checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL zero_reg_stall: got %b expected 0", stall_out); end
      step();
      checks++; if (ex_fwd_a_sel !== 2'd0 || ex_fwd_b_sel !== 2'd0) begin errors++; $display("FAIL zero_reg_sel: got a=%0d b=%0d expected 0/0", ex_fwd_a_sel, ex_fwd_b_sel); end

      drain(4);
      set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b1);   // load to $6
      step();
      set_id(1'b1, 5'd6, 5'd6, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0);   // names $6 but reads neither
      #1;
      checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL unused_src_stall: got %b expected 0", stall_out); end
      step();
      checks++; if (ex_fwd_a_sel !== 2'd0 || ex_fwd_b_sel !== 2'd0) begin errors++; $display("FAIL unused_src_sel: got a=%0d b=%0d expected 0/0", ex_fwd_a_sel, ex_fwd_b_sel); end
   endtask

   task automatic test_redirect();
      drain(4);
      set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0);   // the branch-side instruction
      step();
      set_id(1'b1, 5'd1, 5'd4, 1'b1, 1'b0, 5'd4, 1'b1, 1'b1);   // lw $4
      step();
      set_id(1'b1, 5'd4, 5'd0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);   // load-use consumer
      redirect = 1'b1;
      #1;
      checks++; if (stall_out !== 1'b0 || flush_if_id !== 1'b1 || bubble_id_ex !== 1'b1) begin errors++; $display("FAIL redir_ctrl: got stall=%b flush=%b bubble=%b expected 0/1/1", stall_out, flush_if_id, bubble_id_ex); end
      checks++; if (kill_mask !== 3'b001) begin errors++; $display("FAIL redir_kill: got %b expected 001", kill_mask); end
      exp_flush++;
      step();
      checks++; if (slot_valid !== 3'b100) begin errors++; $display("FAIL redir_slots: got %b expected 100", slot_valid); end
      checks++; if (ex_fwd_a_sel !== 2'd0) begin errors++; $display("FAIL redir_sel: got %0d expected 0", ex_fwd_a_sel); end
      #1;   // redirect still held
      checks++; if (flush_if_id !== 1'b1 || kill_mask !== 3'b001) begin errors++; $display("FAIL redir_held: got flush=%b kill=%b expected 1/001", flush_if_id, kill_mask); end
      exp_flush++;
      step();
      redirect = 1'b0;
      checks++; if (slot_valid !== 3'b000) begin errors++; $display("FAIL redir_held_slots: got %b expected 000", slot_valid); end
   endtask

   task automatic test_counters();
      drain(1);
      checks++; if (stall_cnt !== (PERF ? 16'(exp_stall) : 16'd0)) begin errors++; $display("FAIL stall_cnt: got %0d expected %0d", stall_cnt, PERF ? exp_stall : 0); end
      checks++; if (flush_cnt !== (PERF ? 16'(exp_flush) : 16'd0)) begin errors++; $display("FAIL flush_cnt: got %0d expected %0d", flush_cnt, PERF ? exp_flush : 0); end
   endtask

   task automatic test_small_redirect();
      drain(9);
      s_redirect = 1'b1;
      #1;
      checks++; if (s_kill_mask !== 8'h0F || s_flush_if_id !== 1'b1 || s_bubble_id_ex !== 1'b1) begin errors++; $display("FAIL small_redir: got kill=%0h flush=%b bubble=%b expected 0f/1/1", s_kill_mask, s_flush_if_id, s_bubble_id_ex); end
      s_exp_flush++;
      step();
      s_redirect = 1'b0;
   endtask

   task automatic test_small_stall_len();
      int n;
      drain(9);
      s_set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b1);  // lw $4
      step();
      s_set_id(1'b1, 5'd4, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0);  // consumer of $4
      #1;
      n = 0;
      while (s_stall_out === 1'b1 && n < 20) begin
         n++;
         step();
         #1;
      end
      checks++; if (n !== 6) begin errors++; $display("FAIL small_stall_len: got %0d cycles expected 6", n); end
      s_exp_stall += 6;
      step();
      checks++; if (s_fwd_a_sel !== 3'd7 || s_fwd_b_sel !== 3'd0) begin errors++; $display("FAIL small_fwd_sel: got a=%0d b=%0d expected 7/0", s_fwd_a_sel, s_fwd_b_sel); end
   endtask

   task automatic test_small_saturation();
      int exp_sat;
      drain(9);
      // Self-dependent load: issue, 6 stalls, issue, ... -> 24 stalls in 28 cycles.
      s_set_id(1'b1, 5'd4, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b1);
      repeat (28) step();
      s_exp_stall += 24;
      drain(1);
      exp_sat = (s_exp_stall > 15) ? 15 : s_exp_stall;
      checks++; if (s_stall_cnt !== (PERF ? 4'(exp_sat) : 4'd0)) begin errors++; $display("FAIL small_stall_sat: got %0d expected %0d", s_stall_cnt, PERF ? exp_sat : 0); end
      checks++; if (s_flush_cnt !== (PERF ? 4'(s_exp_flush) : 4'd0)) begin errors++; $display("FAIL small_flush_cnt: got %0d expected %0d", s_flush_cnt, PERF ? s_exp_flush : 0); end
   endtask

   task automatic test_reset_mid();
      drain(4);
      set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b1);   // lw $4
      step();
      set_id(1'b1, 5'd4, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0);   // consumer -> stall pending
      #1;
      checks++; if (stall_out !== 1'b1) begin errors++; $display("FAIL rmid_pre_stall: got %b expected 1", stall_out); end
      #1 rst = 1'b0;
      #1;
      exp_stall = 0; exp_flush = 0;
      checks++; if (stall_out !== 1'b0 || bubble_id_ex !== 1'b0) begin errors++; $display("FAIL rmid_async: got stall=%b bubble=%b expected 0/0", stall_out, bubble_id_ex); end
      checks++; if (slot_valid !== 3'b000 || s_slot_valid !== 8'h00) begin errors++; $display("FAIL rmid_slots: got %b/%0h expected 000/00", slot_valid, s_slot_valid); end
      checks++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0 || s_stall_cnt !== 4'd0) begin errors++; $display("FAIL rmid_cnt: got %0d/%0d/%0d expected 0/0/0", stall_cnt, flush_cnt, s_stall_cnt); end
      step();
      rst = 1'b1;
      checks++; if (ex_fwd_a_sel !== 2'd0 || ex_fwd_b_sel !== 2'd0) begin errors++; $display("FAIL rmid_sel: got a=%0d b=%0d expected 0/0", ex_fwd_a_sel, ex_fwd_b_sel); end
      #1;
      checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL rmid_post_stall: got %b expected 0", stall_out); end
      step();
      checks++; if (ex_fwd_a_sel !== 2'd0 || slot_valid !== 3'b001) begin errors++; $display("FAIL rmid_post_issue: got sel=%0d valid=%b expected 0/001", ex_fwd_a_sel, slot_valid); end
   endtask

   initial begin
      test_reset();
      test_alu_fwd();
      test_load_use();
      test_youngest();
      test_redirect();
      test_counters();
      test_small_redirect();
      test_small_stall_len();
      test_small_saturation();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
